sprite_rom_arbiter: RTL and testbench
=====================================

# sprite_rom_arbiter

Shares one sprite ROM (one read per clock, registered output clocked on the falling edge of `vga_clk`) between several requesters, such as the tank, bullet and map sprite drawers. Requesters arbitrate round-robin. A requester may lock the ROM for a burst of consecutive reads, for example a 32-pixel sprite row, up to a bounded length. The block sits between the sprite drawers and the `*_rom` instance and returns the ROM index byte, which still needs palette lookup, to the requester that issued the read.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `ADDR_W`, 10: ROM address width.
- `DATA_W`, 8: ROM word (palette index) width.
- `MAX_BURST`, 32: maximum cycles a locked owner may hold the ROM while others wait.

- `vga_clk`  in  1  pixel clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester read request.
- `lock`  in  NUM_REQ  per-requester burst-lock request; meaningful only with `req`.
- `addr`  in  NUM_REQ×ADDR_W  per-requester read address; held stable while `req` is high and `gnt` is low.
- `gnt`  out  NUM_REQ  one-hot, combinational; `req[i]&gnt[i]` at a rising edge means the read is accepted.
- `rvalid`  out  NUM_REQ  one-hot, registered; marks `rdata` for requester i.
- `rdata`  out  DATA_W  registered ROM data, shared by all requesters.
- `rom_address`  out  ADDR_W  registered address driving the ROM.
- `rom_q`  in  DATA_W  ROM output; valid one full cycle after `rom_address` changes.

## Operation
- FSM `ARB` / `LOCKED`; registers: `state`, `owner`, `rr_ptr`, `burst_cnt` (6 bits min, sized for `MAX_BURST`), and a 2-stage `id` pipeline.
- ARB: winner is the first requester with `req` high, searching from `rr_ptr+1` mod `NUM_REQ`. `gnt[winner]=1`, then `rr_ptr<=winner`. If `lock[winner]`, go to LOCKED with `owner<=winner` and `burst_cnt<=1`.
- LOCKED: only `owner` can be granted, `gnt[owner]=req[owner]`. `burst_cnt` increments every LOCKED cycle, idle or not.
- LOCKED→ARB when any of these holds:
  - `lock[owner]` is low;
  - `burst_cnt==MAX_BURST` and another requester has `req` high (no grant in that cycle, a bubble);
  - `req[owner]` and `lock[owner]` are both low.
- If `burst_cnt` reaches `MAX_BURST` with no other requester waiting, the owner keeps the ROM, and `burst_cnt` saturates.
- Accepted read: `rom_address<=addr[winner]` and `id1<=winner` with valid. Next edge: `rdata<=rom_q`, `rvalid<=onehot(id1)`.
- Throughput is one read per cycle, back-to-back across different requesters.
- Reset values: `state=ARB`, `rr_ptr=NUM_REQ-1` (requester 0 first), `owner=0`, `burst_cnt=0`, `rom_address=0`, `rdata=0`, `rvalid=0`, pipeline valids 0. `gnt` is 0 whenever `req` is 0.
- Reset asserted mid-operation discards in-flight reads; no `rvalid` follows the release of reset.
- Simultaneous requests: exactly one `gnt` per cycle, never more.

## Timing
- Cycle 0: `req&gnt` accepted at the rising edge ending cycle 0.
- Cycle 1: `rom_address` valid; the ROM samples it on the `vga_clk` falling edge.
- Cycle 2: `rdata` and `rvalid[i]` valid for exactly one cycle. Fixed latency is 2 cycles.
- `gnt` depends combinationally on `req`, `lock`, `state`, `owner` and `rr_ptr`, with no path from `rom_q`.
- Burst release bubble is exactly one cycle. The first competing requester is granted in the following cycle.

## Structure
- Package `sprite_arb_pkg`: `typedef enum logic {ARB, LOCKED} arb_state_t`; `localparam` defaults for `NUM_REQ`, `ADDR_W`, `DATA_W`, `MAX_BURST`.
- Sub-module `rr_picker`: combinational round-robin priority encoder, with inputs `req` vector and `ptr`, outputs one-hot `grant` and `any`.
- Top level holds the FSM, the address and ID pipeline, and the output registers. Target size is about 180 lines.

## Test plan
- Reset: hold `reset_n=0` with all `req=1` → `gnt=0`, `rvalid=0`, `rdata=0`. After release, the first grant goes to requester 0.
- Single read: `req[2]=1`, `addr[2]=0x155`, ROM word 0x155=0xA7 → `gnt[2]` in cycle 0, `rom_address=0x155` in cycle 1, `rvalid=4'b0100` and `rdata=0xA7` in cycle 2.
- Fairness: `req=4'b1111` held 8 cycles with no locks → grant order 0,1,2,3,0,1,2,3. Each requester gets `rvalid` 2 cycles after its grant.
- Burst: `req[1]`, `lock[1]` held, `req[3]` held, `MAX_BURST=32` → 32 consecutive grants to 1, one bubble cycle, then `gnt[3]`.
- Lock drop: owner 0 locks for 5 reads then drops `lock` while `req[2]` is waiting → `gnt[2]` in the next cycle with no bubble, and `rr_ptr` continues from 0.
- Reset mid-burst: assert `reset_n=0` one cycle after an accepted read → no `rvalid` ever appears for that read. After release, state is ARB and grants restart at requester 0.

Source files
------------

// File: rtl/sprite_arb_pkg.sv
// Shared types and default sizes for the sprite ROM arbiter.
package sprite_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int unsigned NUM_REQ_DEF   = 4;
    localparam int unsigned ADDR_W_DEF    = 10;
    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned MAX_BURST_DEF = 32;

endpackage

// File: rtl/sprite_rom_arbiter_rr_picker.sv
// Round-robin priority encoder: grants the first requester at or after ptr+1 (mod NUM_REQ).
//   req   : request vector
//   ptr   : last granted requester
//   grant : one-hot grant, zero when no request
//   any   : at least one request present
module rr_picker
    import sprite_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       any
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Walk the ring starting just after ptr; the first hit wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one falling-edge-registered sprite ROM between NUM_REQ sprite drawers.
// Round-robin arbitration with optional bounded burst lock; fixed 2-cycle read latency.
//   vga_clk, reset_n : pixel clock, async active-low reset
//   req, lock, addr  : per-requester read request, burst lock, read address
//   gnt              : combinational one-hot grant (accept = req & gnt at rising edge)
//   rvalid, rdata    : registered one-hot return valid and shared ROM data
//   rom_address      : registered ROM address; rom_q : ROM output
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q
);

    localparam int unsigned PTR_W   = $clog2(NUM_REQ);
    localparam int unsigned CNT_RAW = $clog2(MAX_BURST + 1);
    localparam int unsigned CNT_W   = (CNT_RAW > 6) ? CNT_RAW : 6;

    arb_state_t         state, state_nxt;
    logic [PTR_W-1:0]   owner, owner_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_nxt;

    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_any;
    logic [PTR_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] gnt_c;
    logic [PTR_W-1:0]   acc_idx;
    logic               others_req;
    logic               accept;

    logic               id1_vld;
    logic [PTR_W-1:0]   id1;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .any   (pick_any)
    );

    // Binary index of the round-robin winner.
    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    assign others_req = |(req & ~(NUM_REQ'(1) << owner));

    // Next-state and grant logic.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        gnt_c         = '0;
        acc_idx       = owner;
        case (state)
            ARB: begin
                acc_idx = pick_idx;
                if (pick_any) begin
                    gnt_c      = pick_grant;
                    rr_ptr_nxt = pick_idx;
                    if (lock[pick_idx]) begin
                        state_nxt     = LOCKED;
                        owner_nxt     = pick_idx;
                        burst_cnt_nxt = CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                // Counts every locked cycle, saturating at the burst bound.
                if (burst_cnt < CNT_W'(MAX_BURST)) begin
                    burst_cnt_nxt = burst_cnt + CNT_W'(1);
                end
                if (!lock[owner]) begin
                    // Unlocked final read (if any); arbitration resumes next cycle.
                    gnt_c[owner] = req[owner];
                    state_nxt    = ARB;
                end else if ((burst_cnt >= CNT_W'(MAX_BURST)) && others_req) begin
                    // Forced release: one bubble cycle with no grant.
                    state_nxt = ARB;
                end else begin
                    gnt_c[owner] = req[owner];
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    assign gnt    = reset_n ? gnt_c : '0;
    assign accept = |gnt_c;

    // Arbitration state register.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ARB;
            owner     <= '0;
            rr_ptr    <= PTR_W'(NUM_REQ - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Address stage then return stage; the id rides alongside the ROM access.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_address <= '0;
            id1_vld     <= 1'b0;
            id1         <= '0;
            rvalid      <= '0;
            rdata       <= '0;
        end else begin
            id1_vld <= accept;
            if (accept) begin
                rom_address <= addr[32'(acc_idx) * ADDR_W +: ADDR_W];
                id1         <= acc_idx;
            end
            rvalid <= id1_vld ? (NUM_REQ'(1) << id1) : '0;
            if (id1_vld) begin
                rdata <= rom_q;
            end
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a cycle-level behavioural model and a falling-edge ROM.
module tb_sprite_rom_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 32;

    logic                      vga_clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic [NUM_REQ-1:0]        req     = '1;
    logic [NUM_REQ-1:0]        lock    = '0;
    logic [NUM_REQ*ADDR_W-1:0] addr    = {10'h2E1, 10'h155, 10'h0C3, 10'h07A};
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         rom_address;
    logic [DATA_W-1:0]         rom_q   = '0;

    int n_cmp = 0;
    int n_err = 0;

    sprite_rom_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .req         (req),
        .lock        (lock),
        .addr        (addr),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .rom_address (rom_address),
        .rom_q       (rom_q)
    );

    always #5 vga_clk = ~vga_clk;

    // ROM contents: fixed function of the address, with the documented test word.
    function automatic logic [7:0] rom_word(input logic [9:0] a);
        if (a == 10'h155) return 8'hA7;
        return a[7:0] ^ {a[9:8], a[9:4]} ^ 8'h5A;
    endfunction

    always @(negedge vga_clk) rom_q <= rom_word(rom_address);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit has_bit(input logic [31:0] v, input int i);
        return ((v >> i) & 32'd1) != 32'd0;
    endfunction

    // Behavioural model: arbitration rules on integers plus a per-cycle log of accepted reads.
    int          cyc = 0;
    bit          m_locked;
    int          m_owner, m_ptr, m_cnt;
    bit          log_v  [int];
    int          log_id [int];
    logic [9:0]  log_a  [int];
    logic [9:0]  ra_hold;
    logic [7:0]  rd_hold;
    logic [31:0] exp_rv, exp_gnt;
    int          win, cand;
    bit          others;

    function automatic bit logged(input int c);
        return log_v.exists(c) ? log_v[c] : 1'b0;
    endfunction

    always @(negedge vga_clk) begin
        if (!reset_n) begin
            m_locked = 1'b0; m_owner = 0; m_ptr = NUM_REQ - 1; m_cnt = 0;
            ra_hold  = '0;   rd_hold = '0;
            log_v[cyc] = 1'b0;
            if (cyc >= 1) log_v[cyc-1] = 1'b0;
            check("rst_gnt",    32'(gnt),         32'd0);
            check("rst_rvalid", 32'(rvalid),      32'd0);
            check("rst_rdata",  32'(rdata),       32'd0);
            check("rst_raddr",  32'(rom_address), 32'd0);
        end else begin
            if (cyc >= 1 && logged(cyc-1)) ra_hold = log_a[cyc-1];
            exp_rv = '0;
            if (cyc >= 2 && logged(cyc-2)) begin
                exp_rv  = 32'd1 << log_id[cyc-2];
                rd_hold = rom_word(log_a[cyc-2]);
            end
            win = -1;
            if (!m_locked) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    cand = (m_ptr + k) % NUM_REQ;
                    if (win < 0 && has_bit(32'(req), cand)) win = cand;
                end
                if (win >= 0) begin
                    m_ptr = win;
                    if (has_bit(32'(lock), win)) begin
                        m_locked = 1'b1; m_owner = win; m_cnt = 1;
                    end
                end
            end else begin
                others = 1'b0;
                for (int i = 0; i < NUM_REQ; i++)
                    if (i != m_owner && has_bit(32'(req), i)) others = 1'b1;
                if (!has_bit(32'(lock), m_owner)) begin
                    if (has_bit(32'(req), m_owner)) win = m_owner;
                    m_locked = 1'b0;
                end else if (m_cnt >= MAX_BURST && others) begin
                    m_locked = 1'b0;
                end else if (has_bit(32'(req), m_owner)) begin
                    win = m_owner;
                end
                m_cnt = (m_cnt < MAX_BURST) ? m_cnt + 1 : MAX_BURST;
            end
            exp_gnt = (win >= 0) ? (32'd1 << win) : 32'd0;
            check("gnt",         32'(gnt),          exp_gnt);
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("rvalid",      32'(rvalid),       exp_rv);
            check("rdata",       32'(rdata),        32'(rd_hold));
            check("rom_address", 32'(rom_address),  32'(ra_hold));
            log_v[cyc] = (win >= 0);
            if (win >= 0) begin
                log_id[cyc] = win;
                log_a[cyc]  = 10'(addr >> (win * ADDR_W));
            end
        end
        cyc++;
    end

    task automatic step(input logic [3:0] r, input logic [3:0] l);
        @(posedge vga_clk); #1;
        req = r; lock = l;
    endtask

    task automatic settle;
        @(negedge vga_clk); #2;
    endtask

    task automatic do_reset;
        @(posedge vga_clk); #1;
        reset_n = 1'b0; req = '0; lock = '0;
        repeat (2) @(posedge vga_clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        // Reset with every requester asking.
        settle;
        check("t_rst_gnt",    32'(gnt),    32'h0);
        check("t_rst_rvalid", 32'(rvalid), 32'h0);
        check("t_rst_rdata",  32'(rdata),  32'h0);
        @(posedge vga_clk); #1 reset_n = 1'b1;
        settle;
        check("t_rst_first_gnt", 32'(gnt), 32'h1);

        // Single read from requester 2.
        do_reset;
        step(4'b0100, 4'b0000); settle;
        check("t_single_gnt", 32'(gnt), 32'h4);
        step(4'b0000, 4'b0000); settle;
        check("t_single_raddr", 32'(rom_address), 32'h155);
        step(4'b0000, 4'b0000); settle;
        check("t_single_rvalid", 32'(rvalid), 32'h4);
        check("t_single_rdata",  32'(rdata),  32'hA7);
        step(4'b0000, 4'b0000); settle;
        check("t_single_rvalid_off", 32'(rvalid), 32'h0);

        // Fairness: all request, no locks.
        do_reset;
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 4'b0000); settle;
            check("t_fair_gnt", 32'(gnt), 32'd1 << (k % 4));
            if (k >= 2) check("t_fair_rvalid", 32'(rvalid), 32'd1 << ((k - 2) % 4));
        end
        repeat (3) step(4'b0000, 4'b0000);

        // Burst: requester 1 locks while 3 waits.
        do_reset;
        for (int k = 0; k < 32; k++) begin
            step(4'b1010, 4'b0010); settle;
            check("t_burst_gnt1", 32'(gnt), 32'h2);
        end
        step(4'b1010, 4'b0010); settle;
        check("t_burst_bubble", 32'(gnt), 32'h0);
        step(4'b1010, 4'b0010); settle;
        check("t_burst_gnt3", 32'(gnt), 32'h8);
        repeat (3) step(4'b0000, 4'b0000);

        // Saturated burst with nobody waiting, then a competitor arrives.
        do_reset;
        repeat (40) step(4'b0010, 4'b0010);
        step(4'b1010, 4'b0010); settle;
        check("t_sat_bubble", 32'(gnt), 32'h0);
        step(4'b1010, 4'b0010); settle;
        check("t_sat_gnt3", 32'(gnt), 32'h8);
        repeat (3) step(4'b0000, 4'b0000);

        // Lock drop: owner 0 reads five times, the last unlocked, while 2 waits.
        do_reset;
        for (int k = 0; k < 4; k++) begin
            step(4'b0101, 4'b0001); settle;
            check("t_drop_gnt0", 32'(gnt), 32'h1);
        end
        step(4'b0101, 4'b0000); settle;
        check("t_drop_last0", 32'(gnt), 32'h1);
        step(4'b0101, 4'b0000); settle;
        check("t_drop_gnt2", 32'(gnt), 32'h4);
        repeat (3) step(4'b0000, 4'b0000);

        // Reset one cycle after an accepted read.
        do_reset;
        step(4'b0010, 4'b0010); settle;
        check("t_mid_gnt", 32'(gnt), 32'h2);
        @(posedge vga_clk); #1 reset_n = 1'b0;
        settle;
        check("t_mid_rvalid_a", 32'(rvalid), 32'h0);
        @(posedge vga_clk); #1;
        settle;
        check("t_mid_rvalid_b", 32'(rvalid), 32'h0);
        @(posedge vga_clk); #1;
        reset_n = 1'b1; req = 4'b1111; lock = 4'b0000;
        settle;
        check("t_mid_gnt0",     32'(gnt),    32'h1);
        check("t_mid_rvalid_c", 32'(rvalid), 32'h0);
        step(4'b1111, 4'b0000); settle;
        check("t_mid_gnt1",     32'(gnt),    32'h2);
        check("t_mid_rvalid_d", 32'(rvalid), 32'h0);
        repeat (4) step(4'b0000, 4'b0000);

        @(posedge vga_clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
